// File: rtl/timer_bcd_n.sv
// BCD stopwatch/countdown core: per-digit modulus chain with presets, lap hold and done pulse.
// Latency: input edges act two mclk edges after first sampling; there is no backpressure, and every edge is consumed or dropped.
module timer_bcd_n #(
    parameter int                  DIGITS    = 6,
    parameter logic [4*DIGITS-1:0] DIGIT_MAX = 24'h595999,
    localparam int                 SEL_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                  mclk,
    input  logic                  rst_n,
    input  logic                  tick,
    input  logic                  dir,
    input  logic                  start_stop,
    input  logic                  clear,
    input  logic                  lap,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  inc,
    input  logic                  dec,
    output logic [4*DIGITS-1:0]   count,
    output logic [4*DIGITS-1:0]   disp,
    output logic                  running,
    output logic                  done,
    output logic                  lap_active
);

    localparam int CW = 4 * DIGITS;
    localparam int E_TICK = 0;
    localparam int E_SS   = 1;
    localparam int E_CLR  = 2;
    localparam int E_LAP  = 3;
    localparam int E_INC  = 4;
    localparam int E_DEC  = 5;

    typedef enum logic {ST_STOP, ST_RUN} state_t;

    state_t        state, state_nxt;
    logic [5:0]    raw, s1, s2, s3, edges;
    logic          dir_s1, dir_s2;
    logic [CW-1:0] term, step_val, edit_val, count_nxt, disp_nxt;
    logic          lap_nxt, done_nxt;

    assign raw     = {dec, inc, lap, clear, start_stop, tick};
    assign edges   = s2 & ~s3;
    assign term    = dir_s2 ? DIGIT_MAX : '0;
    assign running = (state == ST_RUN);

    // Conditioning flops reset high so a level already asserted at release is not an edge.
    always_ff @(posedge mclk) begin
        if (!rst_n) begin
            s1     <= '1;
            s2     <= '1;
            s3     <= '1;
            dir_s1 <= 1'b0;
            dir_s2 <= 1'b0;
        end else begin
            s1     <= raw;
            s2     <= s1;
            s3     <= s2;
            dir_s1 <= dir;
            dir_s2 <= dir_s1;
        end
    end

    // One tick step: carry (up) or borrow (down) ripples while lower digits wrap.
    always_comb begin
        logic       chain;
        logic [3:0] d, m;
        step_val = count;
        chain    = 1'b1;
        d        = 4'd0;
        m        = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            d = count[4*i +: 4];
            m = DIGIT_MAX[4*i +: 4];
            if (chain) begin
                if (dir_s2) begin
                    if (d >= m) begin
                        step_val[4*i +: 4] = 4'd0;
                    end else begin
                        step_val[4*i +: 4] = d + 4'd1;
                        chain              = 1'b0;
                    end
                end else begin
                    if (d == 4'd0) begin
                        step_val[4*i +: 4] = m;
                    end else begin
                        step_val[4*i +: 4] = d - 4'd1;
                        chain              = 1'b0;
                    end
                end
            end
        end
    end

    // Single-digit preset edit; out-of-range sel matches no digit.
    always_comb begin
        logic [3:0] d, m;
        edit_val = count;
        d        = 4'd0;
        m        = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            d = count[4*i +: 4];
            m = DIGIT_MAX[4*i +: 4];
            if (int'(sel) == i) begin
                if (edges[E_INC]) edit_val[4*i +: 4] = (d >= m) ? 4'd0 : d + 4'd1;
                else              edit_val[4*i +: 4] = (d == 4'd0) ? m : d - 4'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        done_nxt  = 1'b0;
        lap_nxt   = edges[E_LAP] ? ~lap_active : lap_active;
        disp_nxt  = disp;
        case (state)
            ST_STOP: begin
                if (edges[E_SS]) begin
                    if (count != term) state_nxt = ST_RUN;
                end else if (edges[E_CLR]) begin
                    count_nxt = '0;
                    lap_nxt   = 1'b0;
                end else if (edges[E_INC] || edges[E_DEC]) begin
                    count_nxt = edit_val;
                end
            end
            ST_RUN: begin
                if (edges[E_SS]) begin
                    state_nxt = ST_STOP;
                end else if (edges[E_TICK]) begin
                    // Already terminal happens when dir flips mid-run; stop without stepping.
                    if (count == term) begin
                        state_nxt = ST_STOP;
                        done_nxt  = 1'b1;
                    end else begin
                        count_nxt = step_val;
                        if (step_val == term) begin
                            state_nxt = ST_STOP;
                            done_nxt  = 1'b1;
                        end
                    end
                end
            end
            default: state_nxt = ST_STOP;
        endcase
        if (!lap_nxt)          disp_nxt = count_nxt;
        else if (!lap_active)  disp_nxt = count;
    end

    always_ff @(posedge mclk) begin
        if (!rst_n) begin
            state      <= ST_STOP;
            count      <= '0;
            disp       <= '0;
            done       <= 1'b0;
            lap_active <= 1'b0;
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            disp       <= disp_nxt;
            done       <= done_nxt;
            lap_active <= lap_nxt;
        end
    end

endmodule
